// File: rtl/pe_col_drain.sv
// Column drain below the bottom PE: accumulates partial sums across passes,
// requantizes on the final pass and queues results for a valid/ready consumer.
module pe_col_drain #(
    parameter int L_WIDTH = 32,
    parameter int S_WIDTH = 8,
    parameter int ACC_LEN = 16,
    parameter int DEPTH   = 4
) (
    input  logic                       DR_clk,
    input  logic                       DR_rst,
    input  logic                       DR_clr,
    input  logic                       DR_mode,
    input  logic                       DR_en_up,
    input  logic signed [L_WIDTH-1:0]  DR_data_up,
    input  logic                       DR_first_pass,
    input  logic                       DR_last_pass,
    input  logic [4:0]                 DR_shift,
    input  logic                       DR_relu,
    output logic                       DR_out_valid,
    input  logic                       DR_out_ready,
    output logic signed [S_WIDTH-1:0]  DR_out_data,
    output logic                       DR_out_last,
    output logic                       DR_overflow,
    output logic [$clog2(ACC_LEN)-1:0] DR_idx
);

    localparam int IW = $clog2(ACC_LEN);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(ACC_LEN - 1);
    localparam logic signed [L_WIDTH-1:0] SAT_MAX = L_WIDTH'((1 << (S_WIDTH - 1)) - 1);
    localparam logic signed [L_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [L_WIDTH-1:0] acc [ACC_LEN];
    logic [S_WIDTH-1:0]        fifo_data [DEPTH];
    logic                      fifo_last [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [CW-1:0]             count;

    logic                      accept;
    logic                      pop;
    logic                      full;
    logic                      push;
    logic                      drop;
    logic signed [L_WIDTH-1:0] sum;
    logic signed [L_WIDTH-1:0] shifted;
    logic signed [L_WIDTH-1:0] clamped;
    logic [S_WIDTH-1:0]        result;

    always_comb begin
        accept  = DR_en_up & ~DR_mode & ~DR_clr;
        sum     = DR_first_pass ? DR_data_up : acc[DR_idx] + DR_data_up;
        shifted = sum >>> DR_shift;
        clamped = shifted;
        if (DR_relu && shifted[L_WIDTH-1]) begin
            clamped = '0;
        end
        if (clamped > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (clamped < SAT_MIN) begin
            clamped = SAT_MIN;
        end
        result = clamped[S_WIDTH-1:0];
        pop    = DR_out_valid & DR_out_ready;
        full   = (count == CW'(DEPTH));
        // a slot freed by a same-cycle pop is reused, so only a truly full FIFO drops
        push   = accept & DR_last_pass & (~full | pop);
        drop   = accept & DR_last_pass & full & ~pop;
    end

    assign DR_out_valid = (count != '0);
    assign DR_out_data  = fifo_data[rd_ptr];
    assign DR_out_last  = fifo_last[rd_ptr];

    always_ff @(posedge DR_clk or posedge DR_rst) begin
        if (DR_rst) begin
            DR_idx      <= '0;
            DR_overflow <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < ACC_LEN; i++) begin
                acc[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else if (DR_clr) begin
            DR_idx      <= '0;
            DR_overflow <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (accept) begin
                acc[DR_idx] <= sum;
                DR_idx      <= (DR_idx == IDX_MAX) ? '0 : DR_idx + 1'b1;
            end
            if (drop) begin
                DR_overflow <= 1'b1;
            end
            if (push) begin
                fifo_data[wr_ptr] <= result;
                fifo_last[wr_ptr] <= (DR_idx == IDX_MAX);
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_col_drain.sv
// Randomized and directed bench for pe_col_drain against a queue-based model.
module tb_pe_col_drain;

    localparam int L   = 32;
    localparam int S   = 8;
    localparam int ACC = 16;
    localparam int DEP = 4;

    logic clk = 1'b0;
    logic rst, clr, mode, en, first, last, relu, ready;
    logic signed [L-1:0] data;
    logic [4:0] shift;
    logic out_valid, out_last, ov;
    logic signed [S-1:0] out_data;
    logic [3:0] idx;

    typedef struct {
        int d;
        bit l;
    } ent_t;

    int   m_acc [ACC];
    int   m_idx;
    bit   m_ov;
    ent_t m_q[$];
    ent_t cap[$];
    int   nchk = 0;
    int   nerr = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    pe_col_drain #(.L_WIDTH(L), .S_WIDTH(S), .ACC_LEN(ACC), .DEPTH(DEP)) dut (
        .DR_clk(clk), .DR_rst(rst), .DR_clr(clr), .DR_mode(mode), .DR_en_up(en),
        .DR_data_up(data), .DR_first_pass(first), .DR_last_pass(last),
        .DR_shift(shift), .DR_relu(relu), .DR_out_valid(out_valid),
        .DR_out_ready(ready), .DR_out_data(out_data), .DR_out_last(out_last),
        .DR_overflow(ov), .DR_idx(idx)
    );

    task automatic chk(string name, int act, int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int requant(int s);
        int r;
        r = s >>> shift;
        if (relu && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    task automatic model_reset();
        m_idx = 0;
        m_ov  = 1'b0;
        m_q.delete();
        foreach (m_acc[i]) m_acc[i] = 0;
    endtask

    // one clock: record consumer pops, then advance the model with the same inputs
    task automatic tick();
        ent_t e;
        bit   pop, full, acc_b;
        int   s;
        if (out_valid && ready) begin
            e.d = int'(out_data);
            e.l = out_last;
            cap.push_back(e);
        end
        pop   = (m_q.size() != 0) && ready;
        full  = (m_q.size() == DEP);
        acc_b = en && !mode && !clr;
        @(posedge clk);
        #1;
        if (clr) begin
            m_idx = 0;
            m_q.delete();
            m_ov = 1'b0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (acc_b) begin
                s = first ? int'(data) : m_acc[m_idx] + int'(data);
                m_acc[m_idx] = s;
                if (last) begin
                    if (full && !pop) m_ov = 1'b1;
                    else begin
                        e.d = requant(s);
                        e.l = (m_idx == ACC - 1);
                        m_q.push_back(e);
                    end
                end
                m_idx = (m_idx + 1) % ACC;
            end
        end
    endtask

    task automatic beat(int d, bit f, bit l);
        en = 1'b1; data = d; first = f; last = l;
        tick();
        en = 1'b0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic check_cap(string nm, int ev[$]);
        chk({nm, "_count"}, cap.size(), ev.size());
        for (int i = 0; i < ev.size() && i < cap.size(); i++) chk(nm, cap[i].d, ev[i]);
        cap.delete();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", out_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                chk("out_data", int'(out_data), m_q[0].d);
                chk("out_last", out_last, m_q[0].l);
            end
            chk("overflow", ov, m_ov);
            chk("idx", idx, m_idx);
        end
    end

    initial begin
        int  ev[$];
        bit  need_first;
        rst = 1'b1; clr = 1'b0; mode = 1'b0; en = 1'b0; data = '0;
        first = 1'b0; last = 1'b0; shift = '0; relu = 1'b0; ready = 1'b0;
        model_reset();
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", ov, 0);
        chk("rst_idx", idx, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        cmp_en = 1'b1;

        // single pass ramp
        ready = 1'b1;
        for (int i = 0; i < ACC; i++) begin
            beat(i, 1'b1, 1'b1);
            if (i == 0) chk("latency", out_valid, 1);
        end
        idle(3);
        chk("ramp_last15", cap[15].l, 1);
        chk("ramp_last14", cap[14].l, 0);
        ev.delete();
        for (int i = 0; i < ACC; i++) ev.push_back(i);
        check_cap("ramp", ev);

        // three-pass accumulation
        shift = 5'd2;
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < ACC; i++) beat(100, p == 0, p == 2);
        idle(3);
        ev.delete();
        for (int i = 0; i < ACC; i++) ev.push_back(75);
        check_cap("multipass", ev);

        // saturation and relu
        shift = 5'd0;
        beat(1000, 1, 1); beat(-1000, 1, 1); beat(-5, 1, 1);
        relu = 1'b1;
        beat(1000, 1, 1); beat(-1000, 1, 1); beat(-5, 1, 1);
        relu = 1'b0;
        idle(3);
        ev = {127, -128, -5, 127, 0, 0};
        check_cap("sat_relu", ev);

        // back-pressure and overflow
        clr_tick();
        ready = 1'b0;
        for (int i = 1; i <= 6; i++) beat(i, 1, 1);
        chk("ovf_set", ov, 1);
        chk("model_depth", m_q.size(), 4);
        ready = 1'b1;
        idle(6);
        ev = {1, 2, 3, 4};
        check_cap("backpressure", ev);
        clr_tick();
        chk("ovf_cleared", ov, 0);
        ready = 1'b0;
        for (int i = 11; i <= 14; i++) beat(i, 1, 1);
        ready = 1'b1;
        beat(15, 1, 1);
        chk("full_pop_no_drop", ov, 0);
        idle(6);
        ev = {11, 12, 13, 14, 15};
        check_cap("full_pop", ev);

        // weight-load mode ignores beats
        clr_tick();
        for (int i = 0; i < ACC; i++) beat(10, 1, 0);
        mode = 1'b1;
        for (int i = 0; i < 5; i++) beat(85, 1, 1);
        chk("mode_idx", idx, 0);
        chk("mode_valid", out_valid, 0);
        mode = 1'b0;
        for (int i = 0; i < ACC; i++) beat(1, 0, 1);
        idle(3);
        ev.delete();
        for (int i = 0; i < ACC; i++) ev.push_back(11);
        check_cap("mode_acc", ev);

        // clear mid-pass
        clr_tick();
        ready = 1'b0;
        for (int i = 0; i < 7; i++) beat(3, 1, 1);
        chk("pre_clr_idx", idx, 7);
        chk("pre_clr_ovf", ov, 1);
        clr = 1'b1; en = 1'b1; data = 99; first = 1'b1; last = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        chk("clr_idx", idx, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_ovf", ov, 0);
        ready = 1'b1; shift = 5'd1;
        for (int i = 0; i < ACC; i++) beat(i * 3 - 20, 1, 1);
        idle(3);
        chk("post_clr_first", cap[0].d, -10);
        chk("post_clr_lastval", cap[15].d, 12);
        ev.delete();
        for (int i = 0; i < ACC; i++) ev.push_back((i * 3 - 20) >>> 1);
        check_cap("post_clr", ev);

        // asynchronous reset mid-stream
        ready = 1'b0; shift = 5'd0;
        for (int i = 0; i < 5; i++) beat(50, 1, 1);
        chk("pre_rst_ovf", ov, 1);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_idx", idx, 0);
        chk("arst_ovf", ov, 0);
        chk("arst_data", out_data, 0);
        @(posedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        ready = 1'b1;
        for (int i = 0; i < ACC; i++) beat(7 - i, 1, 1);
        idle(3);
        chk("post_rst_first", cap[0].d, 7);
        cap.delete();

        // randomized traffic
        need_first = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            clr = ($urandom % 100) == 0;
            if (clr) need_first = 1'b1;
            en    = ($urandom % 4) != 0;
            mode  = ($urandom % 10) == 0;
            ready = ($urandom % 4) != 0;
            relu  = $urandom % 2;
            shift = ($urandom % 4 == 0) ? 5'($urandom % 32) : 5'($urandom % 12);
            case ($urandom % 3)
                0:       data = int'($urandom_range(600)) - 300;
                1:       data = int'($urandom_range(100)) - 50;
                default: data = $urandom;
            endcase
            first = need_first ? 1'b1 : (($urandom % 4) == 0);
            last  = $urandom % 2;
            if (en && !mode && !clr && m_idx == ACC - 1) need_first = 1'b0;
            tick();
        end
        clr = 1'b0; en = 1'b0; mode = 1'b0; ready = 1'b1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pe_col_drain.md
# pe_col_drain

Column drain for the systolic CNN array: sits below the bottom PE of one column and consumes that PE's down-going partial-sum stream (enable + 32-bit data). It accumulates partial sums across multiple input-channel passes in a local buffer. On the final pass it requantizes each sum (arithmetic shift, optional ReLU, saturation to S_WIDTH) and queues it in a small FIFO drained by a valid/ready consumer. The array cannot stall, so the drain never back-pressures upstream; FIFO overrun is flagged instead.

## Interface
- L_WIDTH, 32, partial-sum width (matches PE down-port width)
- S_WIDTH, 8, requantized output width (signed)
- ACC_LEN, 16, psums per pass (output positions per tile); ≥2
- DEPTH, 4, output FIFO depth; power of two, ≥2

- DR_clk  in  1  clock
- DR_rst  in  1  reset; one clock, asynchronous, active-high
- DR_clr  in  1  synchronous clear of index, FIFO, overflow flag
- DR_mode  in  1  1 = weight-load in progress; incoming beats are pass-through weights and are ignored
- DR_en_up  in  1  beat valid from bottom PE en_down
- DR_data_up  in  L_WIDTH  signed psum from bottom PE data_down
- DR_first_pass  in  1  level, sampled with each beat: overwrite accumulator
- DR_last_pass  in  1  level, sampled with each beat: emit result
- DR_shift  in  5  arithmetic right-shift amount for requant
- DR_relu  in  1  1 = clamp negatives to 0
- DR_out_valid  out  1  FIFO non-empty
- DR_out_ready  in  1  consumer accepts head
- DR_out_data  out  S_WIDTH  signed head result
- DR_out_last  out  1  head result is position ACC_LEN-1
- DR_overflow  out  1  sticky: a result was dropped
- DR_idx  out  $clog2(ACC_LEN)  current accumulator index

## Operation
- Beat accepted iff DR_en_up & !DR_mode & !DR_clr.
- Index counter idx: +1 per accepted beat, wraps ACC_LEN-1 -> 0; passes are implicit in the wrap.
- sum = DR_first_pass ? DR_data_up : acc[idx] + DR_data_up (L_WIDTH, two's-complement wrap, no saturation); acc[idx] <= sum every accepted beat.
- first & last both high: single-pass; sum = DR_data_up.
- If DR_last_pass: r = sum >>> DR_shift (sign-extending); if DR_relu and r<0 then r=0; saturate r to [-2^(S_WIDTH-1), 2^(S_WIDTH-1)-1]; push {r, idx==ACC_LEN-1} into FIFO.
- Push when FIFO full and no pop the same cycle: entry dropped, DR_overflow <= 1; acc and idx still update.
- Full with pop in the same cycle: push accepted (no drop).
- Pop on DR_out_valid & DR_out_ready. Output is the registered FIFO head (no combinational path from DR_data_up to outputs).
- DR_clr: idx<=0, FIFO emptied, DR_overflow<=0; acc contents undefined (next pass must be first); beat on the clr cycle ignored.
- DR_mode high: no accumulate, no idx change, FIFO still drains.

## Timing
- Reset values: DR_out_valid=0, DR_out_data=0, DR_out_last=0, DR_overflow=0, DR_idx=0; FIFO pointers 0; acc cleared to 0.
- Reset asynchronous on assertion, released synchronously to DR_clk; reset mid-operation discards all state, including queued results.
- Latency: last-pass beat at cycle N -> DR_out_valid=1 with its result at N+1 (FIFO empty before).
- Throughput: one beat per cycle sustained; FIFO sustains one push + one pop per cycle.
- Results leave in beat order; DR_out_last marks every ACC_LEN-th emitted result, aligned to idx wrap.
- DR_out_data/DR_out_last hold stable while DR_out_valid & !DR_out_ready.
- DR_shift, DR_relu, first/last sampled only on accepted-beat cycles.

## Test plan
- Single pass, ACC_LEN=16, shift=0, relu=0, first=last=1, data 0..15 -> outputs 0..15 at one per cycle starting 1 cycle after the first beat; out_last on 15.
- Three passes of constant 100, shift=2, last on pass 3 -> every result is 300>>>2 = 75; no output during passes 1–2.
- Saturation/ReLU: single pass, data {1000, -1000, -5}, relu=0 -> {127, -128, -5}; relu=1 -> {127, 0, 0}.
- Back-pressure: out_ready=0, 6 single-pass beats, DEPTH=4 -> 4 queued, DR_overflow=1; then ready=1 -> first 4 values out in order; full+pop same cycle accepts push without flagging.
- DR_mode=1 with en_up beats of 0x55 -> idx stays 0, no FIFO push, no acc change.
- DR_clr mid-pass at idx=7 (and DR_rst asserted mid-stream) -> idx=0, out_valid=0, overflow=0 next cycle; the next first pass produces correct results.
